// File: rtl/rom_pkg.sv
// Shared constants and types for the ROM stream reader and its output buffer.
package rom_pkg;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 4;
    localparam int ROM_DEPTH = 16;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef logic [ADDR_W:0] len_t;
endpackage

// File: rtl/rom_stream_fifo.sv
// Synchronous FIFO holding {last, data} words between the ROM and the consumer.
module rom_stream_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    import rom_pkg::*;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/rom_stream_reader.sv
// Walks a synchronous ROM from a start address, absorbs its one-cycle read latency
// and streams the words out on a valid/ready interface with a credit-limited buffer.
module rom_stream_reader #(
    parameter int ADDR_W     = rom_pkg::ADDR_W,
    parameter int DATA_W     = rom_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);
    import rom_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   remaining_n;
    logic [ADDR_W-1:0] addr_n;
    logic              issue;
    logic              issue_last;
    logic              done_n;
    logic              credit;

    // Stage 1 of the in-flight pipe is rom_en itself; stage 2 marks data on rom_data.
    logic              s2;
    logic              last1;
    logic              last2;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W:0]   fifo_head;
    logic              head_last;
    logic              pop;

    rom_stream_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s2),
        .din   ({last2, rom_data}),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {head_last, out_data} = fifo_head;
    assign out_valid = !fifo_empty;
    assign out_last  = head_last && out_valid;
    assign pop       = out_valid && out_ready;
    assign busy      = (state != IDLE);

    // A pop in this cycle is deliberately not credited back.
    assign credit = !fifo_full &&
                    (({1'b0, fifo_count} + (CNT_W + 1)'(rom_en) + (CNT_W + 1)'(s2))
                     < (CNT_W + 1)'(FIFO_DEPTH));

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        addr_n      = rom_addr;
        issue       = 1'b0;
        issue_last  = 1'b0;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_n = 1'b1;
                    end else begin
                        issue       = 1'b1;
                        addr_n      = start_addr;
                        remaining_n = len - LEN_ONE;
                        issue_last  = (len == LEN_ONE);
                        state_n     = (len == LEN_ONE) ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                if (credit) begin
                    issue       = 1'b1;
                    addr_n      = rom_addr + ADDR_W'(1);
                    remaining_n = remaining - LEN_ONE;
                    if (remaining == LEN_ONE) begin
                        issue_last = 1'b1;
                        state_n    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last-tagged entry is always the final one in flight or buffered.
                if (pop && head_last) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            remaining <= '0;
            last1     <= 1'b0;
            s2        <= 1'b0;
            last2     <= 1'b0;
            done      <= 1'b0;
        end else begin
            rom_en    <= issue;
            rom_addr  <= addr_n;
            remaining <= remaining_n;
            last1     <= issue_last;
            s2        <= rom_en;
            last2     <= last1;
            done      <= done_n;
        end
    end
endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader against a model of the team 16x4 ROM.
module tb_rom_stream_reader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] len;
    logic       busy;
    logic       done;
    logic       rom_en;
    logic [3:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    int passed = 0;
    int total  = 0;

    logic [3:0] got_data [$];
    logic       got_last [$];
    logic [3:0] addr_seq [$];
    int done_cnt, done_k, first_valid_k, last_vis_k;
    int rom_en_cnt, ahead_cnt;
    bit hold_bad, busy_bad, busy_seen, timed_out;

    always #5 clk = ~clk;

    rom_stream_reader #(
        .ADDR_W(4),
        .DATA_W(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    function automatic logic [3:0] rom_word(input logic [3:0] a);
        case (a)
            4'd0:  return 4'h2;
            4'd1:  return 4'h2;
            4'd2:  return 4'hE;
            4'd3:  return 4'h2;
            4'd4:  return 4'h4;
            4'd5:  return 4'hA;
            4'd6:  return 4'hC;
            4'd7:  return 4'h0;
            4'd8:  return 4'hA;
            4'd9:  return 4'h2;
            4'd10: return 4'hE;
            4'd11: return 4'h2;
            4'd12: return 4'h4;
            4'd13: return 4'hA;
            4'd14: return 4'hC;
            default: return 4'h0;
        endcase
    endfunction

    // ROM drives X whenever it is not enabled, so stray sampling shows up.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_word(rom_addr);
        else        rom_data <= 4'bxxxx;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] packed_words();
        logic [31:0] r = '0;
        foreach (got_data[i]) r = {r[27:0], got_data[i]};
        return r;
    endfunction

    function automatic logic [31:0] packed_addrs();
        logic [31:0] r = '0;
        foreach (addr_seq[i]) r = {r[27:0], addr_seq[i]};
        return r;
    endfunction

    function automatic logic [31:0] packed_lasts();
        logic [31:0] r = '0;
        foreach (got_last[i]) r = {r[30:0], got_last[i]};
        return r;
    endfunction

    task automatic do_req(input logic [3:0] a, input logic [4:0] n, input int stall,
                          input int second_at, input int abort_words);
        int  j;
        int  since;
        bit  seen_valid;
        bit  popped;
        bit  finished;
        got_data.delete();
        got_last.delete();
        addr_seq.delete();
        done_cnt = 0; done_k = -1; first_valid_k = -1; last_vis_k = -1;
        rom_en_cnt = 0; ahead_cnt = 0;
        hold_bad = 0; busy_bad = 0; busy_seen = 0; timed_out = 0;
        seen_valid = 0; popped = 0; since = 0; finished = 0;
        start = 1'b1; start_addr = a; len = n; out_ready = 1'b1;
        tick();
        start = 1'b0;
        j = 0;
        while (!finished) begin
            if (rom_en) begin
                rom_en_cnt++;
                addr_seq.push_back(rom_addr);
                if (!popped) ahead_cnt++;
            end
            if (busy) busy_seen = 1;
            if (done) begin
                done_cnt++;
                done_k = j;
                if (busy) busy_bad = 1;
            end
            if (out_valid && !seen_valid) begin
                seen_valid    = 1;
                first_valid_k = j;
            end
            out_ready = !(seen_valid && since < stall);
            if (seen_valid) since++;
            if (!out_ready && !(out_valid && out_data === rom_word(a))) hold_bad = 1;
            start = (second_at > 0 && j == second_at);
            if (start) begin
                start_addr = 4'd3;
                len        = 5'd2;
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                if (out_last) last_vis_k = j;
                popped = 1;
            end
            tick();
            j++;
            if (abort_words > 0 && got_data.size() >= abort_words) finished = 1;
            if (done_cnt > 0 && j > done_k + 3) finished = 1;
            if (j > 200) begin
                finished  = 1;
                timed_out = 1;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int mm;
        int nlast;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; len = '0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_ctrl", {busy, done, rom_en, out_valid, out_last}, 5'b0);
        check("rst_addr", rom_addr, 4'd0);
        check("rst_data", out_data, 4'd0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 1'b0);

        // addr 0, len 4, no backpressure
        do_req(4'd0, 5'd4, 0, 0, 0);
        check("t1_timeout", timed_out, 0);
        check("t1_first_valid", first_valid_k, 2);
        check("t1_words", packed_words(), 32'h22E2);
        check("t1_lasts", packed_lasts(), 32'b0001);
        check("t1_consecutive", last_vis_k - first_valid_k, 3);
        check("t1_done_time", done_k, last_vis_k + 1);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_busy_at_done", busy_bad, 0);
        check("t1_reads", rom_en_cnt, 4);

        // wrap 15 -> 0
        do_req(4'd14, 5'd4, 0, 0, 0);
        check("t2_timeout", timed_out, 0);
        check("t2_words", packed_words(), 32'hC022);
        check("t2_addrs", packed_addrs(), 32'hEF01);
        check("t2_done_cnt", done_cnt, 1);

        // backpressure for 5 cycles after first valid
        do_req(4'd5, 5'd6, 5, 0, 0);
        check("t3_timeout", timed_out, 0);
        check("t3_words", packed_words(), 32'hAC0A2E);
        check("t3_count", got_data.size(), 6);
        check("t3_hold", hold_bad, 0);
        check("t3_readahead_ok", ahead_cnt <= 4, 1);
        check("t3_reads", rom_en_cnt, 6);
        check("t3_done_cnt", done_cnt, 1);

        // zero-length request
        do_req(4'd7, 5'd0, 0, 0, 0);
        check("t4_timeout", timed_out, 0);
        check("t4_reads", rom_en_cnt, 0);
        check("t4_done_cnt", done_cnt, 1);
        check("t4_done_time", done_k, 0);
        check("t4_busy", busy_seen, 0);

        // full sweep with an ignored second start during RUN
        do_req(4'd0, 5'd16, 0, 3, 0);
        mm = 0;
        nlast = 0;
        for (int i = 0; i < got_data.size(); i++) begin
            if (got_data[i] !== rom_word(4'(i))) mm++;
            if (got_last[i]) nlast++;
        end
        check("t5_timeout", timed_out, 0);
        check("t5_count", got_data.size(), 16);
        check("t5_data", mm, 0);
        check("t5_nlast", nlast, 1);
        check("t5_last16", (got_last.size() == 16) ? got_last[15] : 1'b0, 1'b1);
        check("t5_reads", rom_en_cnt, 16);
        check("t5_done_cnt", done_cnt, 1);

        // reset in the middle of a request
        do_req(4'd0, 5'd16, 0, 0, 3);
        check("t6_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", {busy, done, rom_en, out_valid, out_last}, 5'b0);
        check("t6_rst_addr", rom_addr, 4'd0);
        check("t6_rst_data", out_data, 4'd0);
        done_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (done) done_cnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("t6_no_done", done_cnt, 0);
        do_req(4'd8, 5'd2, 0, 0, 0);
        check("t6_timeout", timed_out, 0);
        check("t6_words", packed_words(), 32'hA2);
        check("t6_done_cnt", done_cnt, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
